mem_stage: RTL and testbench

Memory stage of the 16-bit pipeline, directly downstream of the execute stage. It latches execute results (ALU result, store data, control) into an internal EX/MEM register and performs loads and stores against a variable-latency data memory through a req/ack handshake. While an access is outstanding it stalls upstream. It delivers registered write-back results to the WB stage and flags misaligned, illegal or timed-out accesses.

---
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory stage of the 16-bit pipeline. Latches execute results
//                into an EX/MEM register, performs loads/stores on a
//                variable-latency req/ack data memory, stalls upstream while
//                an access is outstanding and produces registered write-back
//                results. Flags misaligned, illegal and timed-out accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
   parameter int MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [15:0] ex_ALU_out,
   input  logic [15:0] ex_data_2,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_halt,
   input  logic [2:0]  ex_wr_reg,
   input  logic        ex_reg_write,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_wr,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [15:0] dmem_rdata,
   output logic        wb_valid,
   output logic [15:0] wb_data,
   output logic [2:0]  wb_wr_reg,
   output logic        wb_reg_write,
   output logic        wb_halt,
   output logic        err
);

   // Last wait-counter value before an unacknowledged access times out.
   localparam logic [3:0] c_WAIT_LAST = 4'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_HALTED = 2'd2,
      S_ERROR  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   state_t      w_ex_target;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;

   // EX/MEM register
   logic        r_m_valid;
   logic [15:0] r_m_addr;
   logic [15:0] r_m_wdata;
   logic        r_m_rd;
   logic        r_m_wr;
   logic        r_m_halt;
   logic [2:0]  r_m_wr_reg;
   logic        r_m_reg_write;

   // MEM/WB register
   logic        r_wb_valid;
   logic [15:0] r_wb_data;
   logic [2:0]  r_wb_wr_reg;
   logic        r_wb_reg_write;
   logic        r_wb_halt;
   logic        r_err;

   logic        w_stall;
   logic        w_m_memop;
   logic        w_wb_load;
   logic        w_ex_memop;
   logic        w_ex_bad;

   assign w_m_memop  = r_m_rd | r_m_wr;
   assign w_ex_memop = ex_mem_read | ex_mem_write;
   // Odd address or simultaneous read+write can never be issued to memory.
   assign w_ex_bad   = ex_ALU_out[0] | (ex_mem_read & ex_mem_write);

   // Hold upstream while waiting on memory, once dead, or while a halt sits in M.
   assign w_stall = ((r_state == S_ACCESS) && !dmem_ack)
                  || (r_state == S_HALTED)
                  || (r_state == S_ERROR)
                  || (r_m_valid && r_m_halt);

   // An instruction completes either as a non-memory op in IDLE or on the ack.
   assign w_wb_load = r_m_valid
                    && ((!w_m_memop && (r_state == S_IDLE))
                        || ((r_state == S_ACCESS) && dmem_ack));

   // Classify the instruction being accepted from EX into its M-stage state.
   always_comb begin
      w_ex_target = S_IDLE;
      if (ex_valid && w_ex_memop) begin
         w_ex_target = w_ex_bad ? S_ERROR : S_ACCESS;
      end
   end

   // Next-state and wait-counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = 4'd0;
            if (r_m_valid && r_m_halt) begin
               w_state_nxt = S_HALTED;
            end else if (!w_stall) begin
               w_state_nxt = w_ex_target;
            end
         end
         S_ACCESS: begin
            if (dmem_ack) begin
               w_cnt_nxt   = 4'd0;
               w_state_nxt = w_stall ? S_IDLE : w_ex_target;
            end else if (r_cnt == c_WAIT_LAST) begin
               w_cnt_nxt   = 4'd0;
               w_state_nxt = S_ERROR;
            end else begin
               w_cnt_nxt   = r_cnt + 4'd1;
            end
         end
         S_HALTED: begin
            w_cnt_nxt = 4'd0;
         end
         S_ERROR: begin
            w_cnt_nxt = 4'd0;
         end
         default: begin
            w_state_nxt = S_ERROR;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State, counter and sticky error register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if ((w_state_nxt == S_ERROR) && (r_state != S_ERROR)) begin
            r_err <= 1'b1;
         end
      end
   end

   // EX/MEM register: accept from EX whenever the stage is not stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_valid     <= 1'b0;
         r_m_addr      <= 16'd0;
         r_m_wdata     <= 16'd0;
         r_m_rd        <= 1'b0;
         r_m_wr        <= 1'b0;
         r_m_halt      <= 1'b0;
         r_m_wr_reg    <= 3'd0;
         r_m_reg_write <= 1'b0;
      end else if (!w_stall) begin
         r_m_valid     <= ex_valid;
         r_m_addr      <= ex_ALU_out;
         r_m_wdata     <= ex_data_2;
         r_m_rd        <= ex_valid & ex_mem_read;
         r_m_wr        <= ex_valid & ex_mem_write;
         r_m_halt      <= ex_valid & ex_halt;
         r_m_wr_reg    <= ex_wr_reg;
         r_m_reg_write <= ex_valid & ex_reg_write;
      end
   end

   // MEM/WB register: one-cycle valid pulse per completed instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_valid     <= 1'b0;
         r_wb_data      <= 16'd0;
         r_wb_wr_reg    <= 3'd0;
         r_wb_reg_write <= 1'b0;
         r_wb_halt      <= 1'b0;
      end else begin
         r_wb_valid     <= w_wb_load;
         r_wb_reg_write <= w_wb_load & r_m_reg_write;
         r_wb_halt      <= w_wb_load & r_m_halt;
         if (w_wb_load) begin
            r_wb_data   <= r_m_rd ? dmem_rdata : r_m_addr;
            r_wb_wr_reg <= r_m_wr_reg;
         end
      end
   end

   assign stall        = w_stall;
   assign dmem_req     = (r_state == S_ACCESS);
   assign dmem_wr      = r_m_wr;
   assign dmem_addr    = r_m_addr;
   assign dmem_wdata   = r_m_wdata;
   assign wb_valid     = r_wb_valid;
   assign wb_data      = r_wb_data;
   assign wb_wr_reg    = r_wb_wr_reg;
   assign wb_reg_write = r_wb_reg_write;
   assign wb_halt      = r_wb_halt;
   assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage with a behavioural model
//                and directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

   localparam int TB_MAX_WAIT = 4;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic [15:0] ex_ALU_out;
   logic [15:0] ex_data_2;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_halt;
   logic [2:0]  ex_wr_reg;
   logic        ex_reg_write;
   logic        stall;
   logic        dmem_req;
   logic        dmem_wr;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;
   logic        wb_valid;
   logic [15:0] wb_data;
   logic [2:0]  wb_wr_reg;
   logic        wb_reg_write;
   logic        wb_halt;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_stage #(.MAX_WAIT(TB_MAX_WAIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_valid     (ex_valid),
      .ex_ALU_out   (ex_ALU_out),
      .ex_data_2    (ex_data_2),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_halt      (ex_halt),
      .ex_wr_reg    (ex_wr_reg),
      .ex_reg_write (ex_reg_write),
      .stall        (stall),
      .dmem_req     (dmem_req),
      .dmem_wr      (dmem_wr),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_ack     (dmem_ack),
      .dmem_rdata   (dmem_rdata),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .wb_wr_reg    (wb_wr_reg),
      .wb_reg_write (wb_reg_write),
      .wb_halt      (wb_halt),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   // The instruction held in the stage, how long it has waited, and whether
   // the stage is dead (halted or errored). "Accessing" simply means a valid
   // memory op is held and the stage is alive.
   logic        mdl_valid, mdl_rd, mdl_wr, mdl_halt, mdl_regw;
   logic [15:0] mdl_addr, mdl_wdata;
   logic [2:0]  mdl_wreg;
   int          mdl_waited;
   logic        mdl_dead, mdl_err;
   logic        e_wb_valid, e_wb_regw, e_wb_halt;
   logic [15:0] e_wb_data;
   logic [2:0]  e_wb_wreg;

   logic t_memop, t_busy, t_stall, t_complete, t_bad_ex, t_timeout;
   assign t_memop    = mdl_rd | mdl_wr;
   assign t_busy     = mdl_valid && t_memop && !mdl_dead;
   assign t_stall    = (t_busy && !dmem_ack) || mdl_dead || (mdl_valid && mdl_halt);
   assign t_complete = mdl_valid && !mdl_dead && (!t_memop || dmem_ack);
   assign t_bad_ex   = ex_valid && (ex_mem_read || ex_mem_write)
                       && (ex_ALU_out[0] || (ex_mem_read && ex_mem_write));
   assign t_timeout  = t_busy && !dmem_ack && ((mdl_waited + 1) == TB_MAX_WAIT);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mdl_valid <= 1'b0; mdl_rd <= 1'b0; mdl_wr <= 1'b0; mdl_halt <= 1'b0;
         mdl_regw <= 1'b0; mdl_addr <= '0; mdl_wdata <= '0; mdl_wreg <= '0;
         mdl_waited <= 0; mdl_dead <= 1'b0; mdl_err <= 1'b0;
         e_wb_valid <= 1'b0; e_wb_regw <= 1'b0; e_wb_halt <= 1'b0;
         e_wb_data <= '0; e_wb_wreg <= '0;
      end else begin
         e_wb_valid <= t_complete;
         e_wb_regw  <= t_complete && mdl_regw;
         e_wb_halt  <= t_complete && mdl_halt;
         if (t_complete) begin
            e_wb_data <= mdl_rd ? dmem_rdata : mdl_addr;
            e_wb_wreg <= mdl_wreg;
         end
         if (t_busy && !dmem_ack) mdl_waited <= mdl_waited + 1;
         if (!t_stall) begin
            mdl_valid  <= ex_valid;
            mdl_rd     <= ex_valid && ex_mem_read;
            mdl_wr     <= ex_valid && ex_mem_write;
            mdl_halt   <= ex_valid && ex_halt;
            mdl_regw   <= ex_valid && ex_reg_write;
            mdl_addr   <= ex_ALU_out;
            mdl_wdata  <= ex_data_2;
            mdl_wreg   <= ex_wr_reg;
            mdl_waited <= 0;
         end
         mdl_dead <= mdl_dead || t_timeout || (t_complete && mdl_halt) || (!t_stall && t_bad_ex);
         mdl_err  <= mdl_err || t_timeout || (!t_stall && t_bad_ex);
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         check("stall",        16'(stall),        16'(t_stall));
         check("dmem_req",     16'(dmem_req),     16'(t_busy));
         check("err",          16'(err),          16'(mdl_err));
         check("wb_valid",     16'(wb_valid),     16'(e_wb_valid));
         check("wb_reg_write", 16'(wb_reg_write), 16'(e_wb_regw));
         check("wb_halt",      16'(wb_halt),      16'(e_wb_halt));
         if (t_busy) begin
            check("dmem_wr",    16'(dmem_wr), 16'(mdl_wr));
            check("dmem_addr",  dmem_addr,    mdl_addr);
            check("dmem_wdata", dmem_wdata,   mdl_wdata);
         end
         if (e_wb_valid) begin
            check("wb_data",   wb_data,         e_wb_data);
            check("wb_wr_reg", 16'(wb_wr_reg), 16'(e_wb_wreg));
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_ex(input logic v, input logic [15:0] alu, input logic [15:0] d2,
                         input logic rd, input logic wr, input logic hlt,
                         input logic [2:0] wreg, input logic rw);
      ex_valid = v; ex_ALU_out = alu; ex_data_2 = d2; ex_mem_read = rd;
      ex_mem_write = wr; ex_halt = hlt; ex_wr_reg = wreg; ex_reg_write = rw;
   endtask

   task automatic bubble();
      set_ex(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " stall"},        16'(stall),        16'h0);
      check({tag, " dmem_req"},     16'(dmem_req),     16'h0);
      check({tag, " dmem_wr"},      16'(dmem_wr),      16'h0);
      check({tag, " dmem_addr"},    dmem_addr,         16'h0);
      check({tag, " dmem_wdata"},   dmem_wdata,        16'h0);
      check({tag, " wb_valid"},     16'(wb_valid),     16'h0);
      check({tag, " wb_data"},      wb_data,           16'h0);
      check({tag, " wb_wr_reg"},    16'(wb_wr_reg),    16'h0);
      check({tag, " wb_reg_write"}, 16'(wb_reg_write), 16'h0);
      check({tag, " wb_halt"},      16'(wb_halt),      16'h0);
      check({tag, " err"},          16'(err),          16'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bubble();
      dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int req_cnt;
      rst = 1'b1;
      bubble();
      dmem_ack = 1'b0;
      dmem_rdata = 16'h0000;
      repeat (3) @(posedge clk);
      mid();
      check_reset_outputs("reset");
      nxt();
      rst = 1'b0;

      // Non-memory op; stray ack must be ignored.
      set_ex(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1);
      dmem_ack = 1'b1;
      nxt(); bubble();
      mid(); check("alu stall c1", 16'(stall), 16'h0);
      nxt();
      mid();
      check("alu wb_valid", 16'(wb_valid), 16'h1);
      check("alu wb_data", wb_data, 16'h1234);
      check("alu wb_wr_reg", 16'(wb_wr_reg), 16'h3);
      dmem_ack = 1'b0;
      nxt();

      // Load with ack in the third access cycle, ADD queued behind it.
      set_ex(1'b1, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1);
      nxt();
      set_ex(1'b1, 16'h0777, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1);
      mid();
      check("ld3 stall c1", 16'(stall), 16'h1);
      check("ld3 req c1", 16'(dmem_req), 16'h1);
      check("ld3 addr c1", dmem_addr, 16'h0040);
      nxt();
      mid(); check("ld3 stall c2", 16'(stall), 16'h1);
      nxt();
      dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
      mid();
      check("ld3 stall c3", 16'(stall), 16'h0);
      check("ld3 req c3", 16'(dmem_req), 16'h1);
      nxt();
      dmem_ack = 1'b0; dmem_rdata = 16'h0000; bubble();
      mid();
      check("ld3 req c4", 16'(dmem_req), 16'h0);
      check("ld3 wb_data", wb_data, 16'hBEEF);
      check("ld3 wb_wr_reg", 16'(wb_wr_reg), 16'h5);
      nxt();
      mid();
      check("ld3 next wb_data", wb_data, 16'h0777);
      check("ld3 next wb_wr_reg", 16'(wb_wr_reg), 16'h2);
      nxt();

      // Zero-wait store then load.
      set_ex(1'b1, 16'h0010, 16'h00A5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
      nxt();
      set_ex(1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1);
      dmem_ack = 1'b1;
      mid();
      check("zw st req", 16'(dmem_req), 16'h1);
      check("zw st wr", 16'(dmem_wr), 16'h1);
      check("zw st wdata", dmem_wdata, 16'h00A5);
      check("zw st stall", 16'(stall), 16'h0);
      nxt();
      bubble(); dmem_rdata = 16'h00A5;
      mid();
      check("zw ld req", 16'(dmem_req), 16'h1);
      check("zw ld wr", 16'(dmem_wr), 16'h0);
      check("zw ld stall", 16'(stall), 16'h0);
      check("zw st wb_valid", 16'(wb_valid), 16'h1);
      check("zw st wb_reg_write", 16'(wb_reg_write), 16'h0);
      nxt();
      dmem_ack = 1'b0; dmem_rdata = 16'h0000;
      mid();
      check("zw ld wb_data", wb_data, 16'h00A5);
      check("zw ld wb_wr_reg", 16'(wb_wr_reg), 16'h4);
      check("zw req after", 16'(dmem_req), 16'h0);
      nxt();

      // Halt behind an ADD.
      set_ex(1'b1, 16'h0055, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
      nxt();
      set_ex(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
      nxt();
      bubble();
      mid();
      check("halt add wb_data", wb_data, 16'h0055);
      check("halt stall c2", 16'(stall), 16'h1);
      nxt();
      mid(); check("halt wb_halt c3", 16'(wb_halt), 16'h1);
      nxt();
      mid();
      check("halt wb_halt c4", 16'(wb_halt), 16'h0);
      check("halt stall c4", 16'(stall), 16'h1);
      repeat (3) nxt();
      mid(); check("halt stall late", 16'(stall), 16'h1);
      nxt();
      do_reset();

      // Misaligned load.
      set_ex(1'b1, 16'h0011, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1);
      nxt();
      bubble();
      mid();
      check("mis err", 16'(err), 16'h1);
      check("mis req", 16'(dmem_req), 16'h0);
      check("mis stall", 16'(stall), 16'h1);
      repeat (3) nxt();
      mid();
      check("mis stall late", 16'(stall), 16'h1);
      check("mis err late", 16'(err), 16'h1);
      nxt();
      do_reset();

      // Timeout with MAX_WAIT=4.
      set_ex(1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1);
      nxt();
      bubble();
      req_cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         mid();
         if (dmem_req) req_cnt++;
         if (i == 4) check("to err c4", 16'(err), 16'h0);
         if (i == 5) check("to err c5", 16'(err), 16'h1);
         nxt();
      end
      check("to req cycles", 16'(req_cnt), 16'd4);
      mid();
      #1 rst = 1'b1;
      #1 check_reset_outputs("to reset");
      nxt();
      rst = 1'b0;

      // Asynchronous reset in the middle of an access.
      set_ex(1'b1, 16'h0030, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1);
      nxt();
      bubble();
      mid();
      check("async req before", 16'(dmem_req), 16'h1);
      #1 rst = 1'b1;
      #1;
      check("async req dropped", 16'(dmem_req), 16'h0);
      check("async stall", 16'(stall), 16'h0);
      nxt();
      rst = 1'b0;

      // Recovery after reset.
      set_ex(1'b1, 16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1);
      nxt();
      bubble();
      nxt();
      mid();
      check("recover wb_valid", 16'(wb_valid), 16'h1);
      check("recover wb_data", wb_data, 16'h00F0);
      repeat (2) nxt();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
